// File: rtl/cnu_min_sched_if.sv
// Handshake and result bundle for the min-sum check-node scheduler.
// The master side feeds rows and consumes results; the slave side is the scheduler.
interface cnu_min_sched_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 8
);
    logic              start;
    logic [IDX_W-1:0]  deg;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_mag;
    logic              in_sign;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] min1;
    logic [DATA_W-1:0] min2;
    logic [IDX_W-1:0]  idx1;
    logic              sign_prod;
    logic              busy;

    modport master (
        output start, deg, in_valid, in_mag, in_sign, out_ready,
        input  in_ready, out_valid, min1, min2, idx1, sign_prod, busy
    );

    modport slave (
        input  start, deg, in_valid, in_mag, in_sign, out_ready,
        output in_ready, out_valid, min1, min2, idx1, sign_prod, busy
    );
endinterface

// File: rtl/cnu_min_sched.sv
// Sequential min-sum check-node scheduler: tracks min1/min2/idx1/sign over a row.
// Optional macro CNU_OFFSET_EN presents offset-min-sum magnitudes (saturating at 0).
module cnu_min_sched #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 8,
    parameter int OFFSET = 1
) (
    input  logic            clk,
    input  logic            rst,
    cnu_min_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [DATA_W-1:0] MAG_MAX  = {DATA_W{1'b1}};
    localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nxt_s;
    logic [IDX_W-1:0]  deg_r;
    logic [IDX_W-1:0]  count_r;
    logic [IDX_W-1:0]  idx1_r;
    logic [DATA_W-1:0] m1_r;
    logic [DATA_W-1:0] m2_r;
    logic              sign_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              start_ok_s;
    logic              accept_s;
    logic              last_s;

    // Next-state decode plus row-start / message-accept strobes.
    always_comb begin
        state_nxt_s = state_r;
        start_ok_s  = 1'b0;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start && (bus.deg != IDX_ZERO)) begin
                    start_ok_s  = 1'b1;
                    state_nxt_s = ACC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACC: begin
                accept_s = bus.in_valid;
                last_s   = bus.in_valid && (count_r == (deg_r - IDX_ONE));
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ACC;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, handshake flags and the running min/sign accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            deg_r       <= IDX_ZERO;
            count_r     <= IDX_ZERO;
            idx1_r      <= IDX_ZERO;
            m1_r        <= MAG_MAX;
            m2_r        <= MAG_MAX;
            sign_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ACC);
            out_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s != IDLE);
            if (start_ok_s) begin
                deg_r   <= bus.deg;
                count_r <= IDX_ZERO;
                idx1_r  <= IDX_ZERO;
                m1_r    <= MAG_MAX;
                m2_r    <= MAG_MAX;
                sign_r  <= 1'b0;
            end else if (accept_s) begin
                count_r <= count_r + IDX_ONE;
                sign_r  <= sign_r ^ bus.in_sign;
                // Strict compares keep the earliest position on ties.
                if (bus.in_mag < m1_r) begin
                    m2_r   <= m1_r;
                    m1_r   <= bus.in_mag;
                    idx1_r <= count_r;
                end else if (bus.in_mag < m2_r) begin
                    m2_r <= bus.in_mag;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.idx1      = idx1_r;
    assign bus.sign_prod = sign_r;

`ifdef CNU_OFFSET_EN
    function automatic logic [DATA_W-1:0] sat_offset(input logic [DATA_W-1:0] mag);
        logic [31:0] mag_w;
        logic [31:0] off_w;
        mag_w = 32'(mag);
        off_w = 32'(OFFSET);
        if (mag_w > off_w) begin
            sat_offset = DATA_W'(mag_w - off_w);
        end else begin
            sat_offset = {DATA_W{1'b0}};
        end
    endfunction

    assign bus.min1 = sat_offset(m1_r);
    assign bus.min2 = sat_offset(m2_r);
`else
    logic [31:0] unused_offset_s;
    assign unused_offset_s = 32'(OFFSET);
    assign bus.min1 = m1_r;
    assign bus.min2 = m2_r;
`endif

endmodule

// File: tb/tb_cnu_min_sched.sv
// Directed self-checking bench for cnu_min_sched with a row-level min/sign model.
module tb_cnu_min_sched;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    int   row_mag[$];
    int   row_sgn[$];
    bit   row_pending;
    int   exp_min1;
    int   exp_min2;
    int   exp_idx1;
    int   exp_sign;

    cnu_min_sched_if #(.DATA_W(8), .IDX_W(8)) bus ();

    cnu_min_sched #(.DATA_W(8), .IDX_W(8), .OFFSET(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int off(input int v);
`ifdef CNU_OFFSET_EN
        return (v > 1) ? (v - 1) : 0;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Row result from the min-sum definition: global min, first index, min of the rest.
    task automatic model(input int d);
        int m1;
        int i1;
        int m2;
        int s;
        m1 = row_mag[0];
        i1 = 0;
        for (int i = 1; i < d; i++) begin
            if (row_mag[i] < m1) begin
                m1 = row_mag[i];
                i1 = i;
            end
        end
        m2 = 255;
        for (int i = 0; i < d; i++) begin
            if (i != i1 && row_mag[i] < m2) m2 = row_mag[i];
        end
        s = 0;
        for (int i = 0; i < d; i++) s = s ^ row_sgn[i];
        exp_min1 = off(m1);
        exp_min2 = off(m2);
        exp_idx1 = i1;
        exp_sign = s;
    endtask

    // Compare every presented result against the model.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (!row_pending) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("min1", bus.min1, exp_min1);
                check("min2", bus.min2, exp_min2);
                check("idx1", bus.idx1, exp_idx1);
                check("sign_prod", bus.sign_prod, exp_sign);
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_min1"}, bus.min1, off(255));
        check({tag, "_min2"}, bus.min2, off(255));
        check({tag, "_idx1"}, bus.idx1, 0);
        check({tag, "_sign"}, bus.sign_prod, 0);
    endtask

    task automatic run_row(input int d, input bit gaps);
        model(d);
        bus.start = 1'b1;
        bus.deg   = 8'(d);
        @(negedge clk);
        bus.start = 1'b0;
        check("acc_in_ready", bus.in_ready, 1);
        check("acc_busy", bus.busy, 1);
        for (int i = 0; i < d; i++) begin
            if (gaps && (i % 2 == 1)) begin
                bus.in_valid = 1'b0;
                bus.in_mag   = 8'd0;
                @(negedge clk);
                check("gap_in_ready", bus.in_ready, 1);
                check("gap_out_valid", bus.out_valid, 0);
            end
            bus.in_valid = 1'b1;
            bus.in_mag   = 8'(row_mag[i]);
            bus.in_sign  = row_sgn[i][0];
            if (i == d - 1) row_pending = 1'b1;
            @(negedge clk);
            check("out_valid_timing", bus.out_valid, (i == d - 1) ? 1 : 0);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_row(input int hold);
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            bus.start     = 1'b1;
            bus.deg       = 8'd3;
            bus.in_valid  = 1'b1;
            bus.in_mag    = 8'd0;
            @(negedge clk);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_busy", bus.busy, 1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        row_pending   = 1'b0;
        check("release_out_valid", bus.out_valid, 0);
        check("release_busy", bus.busy, 0);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        row_pending   = 1'b0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.deg       = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_mag    = 8'd0;
        bus.in_sign   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);

        row_mag = '{7, 3, 9, 5};
        row_sgn = '{1, 0, 1, 1};
        run_row(4, 1'b0);
        check("lit1_min1", bus.min1, off(3));
        check("lit1_min2", bus.min2, off(5));
        check("lit1_idx1", bus.idx1, 1);
        check("lit1_sign", bus.sign_prod, 1);
        finish_row(0);

        row_mag = '{4, 4, 2};
        row_sgn = '{0, 0, 0};
        run_row(3, 1'b0);
        check("lit_tie3_min1", bus.min1, off(2));
        check("lit_tie3_min2", bus.min2, off(4));
        check("lit_tie3_idx1", bus.idx1, 2);
        finish_row(0);

        row_mag = '{6, 6};
        row_sgn = '{1, 0};
        run_row(2, 1'b0);
        check("lit_tie2_min1", bus.min1, off(6));
        check("lit_tie2_min2", bus.min2, off(6));
        check("lit_tie2_idx1", bus.idx1, 0);
        finish_row(0);

        row_mag = '{8, 2, 6, 2, 9};
        row_sgn = '{0, 1, 1, 0, 1};
        run_row(5, 1'b1);
        finish_row(3);

        bus.in_valid = 1'b1;
        bus.in_mag   = 8'd0;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        row_mag = '{10};
        row_sgn = '{1};
        run_row(1, 1'b0);
        check("lit_deg1_min1", bus.min1, off(10));
        check("lit_deg1_min2", bus.min2, off(255));
        check("lit_deg1_idx1", bus.idx1, 0);
        finish_row(0);

        bus.start = 1'b1;
        bus.deg   = 8'd0;
        @(negedge clk);
        bus.start = 1'b0;
        check("deg0_busy", bus.busy, 0);
        check("deg0_in_ready", bus.in_ready, 0);
        @(negedge clk);
        check("deg0_busy_later", bus.busy, 0);

        bus.start = 1'b1;
        bus.deg   = 8'd6;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_mag   = 8'(i + 1);
            bus.in_sign  = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrow");
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);

        row_mag = '{1, 2};
        row_sgn = '{0, 1};
        run_row(2, 1'b0);
        check("lit_post_min1", bus.min1, off(1));
        check("lit_post_min2", bus.min2, off(2));
        check("lit_post_idx1", bus.idx1, 0);
        finish_row(0);

        row_mag = '{0, 5};
        row_sgn = '{0, 0};
        run_row(2, 1'b0);
        check("lit_off_min1", bus.min1, 0);
        check("lit_off_min2", bus.min2, off(5));
        finish_row(0);

        row_mag = {};
        row_sgn = {};
        for (int i = 0; i < 255; i++) begin
            row_mag.push_back((i * 37 + 11) % 256);
            row_sgn.push_back((i % 3 == 0) ? 1 : 0);
        end
        run_row(255, 1'b0);
        finish_row(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
